regfile_wb_sink: RTL

//  Receiving end of the writeback interface: accepts the retire stream leaving the writeback

---
 rtl/regfile_wb_sink_pkg.sv | 22 ++
 rtl/regfile_wb_sink_if.sv | 34 +++
 rtl/regfile_wb_sink_sb_counter.sv | 48 ++++
 rtl/regfile_wb_sink.sv | 133 +++++++++++++
 4 files changed

// File: rtl/regfile_wb_sink_pkg.sv
// Shared types and constants for the writeback sink / register file block.
// Contents:
//   XLEN, NREG, CNTW, CREG_W - datapath width, GPR count, scoreboard counter width, addr width
//   creg_addr_t              - GPR address
//   regwb_req_t              - retire beat on the writeback -> sink link
package regfile_wb_sink_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREG   = 32;
  localparam int unsigned CNTW   = 2;
  localparam int unsigned CREG_W = 5;

  typedef logic [CREG_W-1:0] creg_addr_t;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    creg_addr_t      dst;
    logic [XLEN-1:0] data;
  } regwb_req_t;

endpackage

// File: rtl/regfile_wb_sink_if.sv
// Writeback and issue link between the pipeline and the register file sink.
// Signals:
//   wb             - retire beat from writeback (valid, regwrite, dst, data)
//   issue_valid    - decode issues an instruction this cycle
//   issue_regwrite - the issued instruction will write a GPR
//   issue_dst      - its destination register
//   issue_ready    - returned by the sink; low means the issue would overflow a counter
// Modports: master = pipeline side, slave = register file sink.
interface regfile_wb_sink_if;
  import regfile_wb_sink_pkg::*;

  regwb_req_t wb;
  logic       issue_valid;
  logic       issue_regwrite;
  creg_addr_t issue_dst;
  logic       issue_ready;

  modport master (
    output wb,
    output issue_valid,
    output issue_regwrite,
    output issue_dst,
    input  issue_ready
  );

  modport slave (
    input  wb,
    input  issue_valid,
    input  issue_regwrite,
    input  issue_dst,
    output issue_ready
  );

endinterface

// File: rtl/regfile_wb_sink_sb_counter.sv
// One pending-write scoreboard counter for a single GPR.
// Ports:
//   clk, reset - rising-edge clock, synchronous active-low reset
//   inc        - an accepted issue targets this register
//   dec        - a writeback commits to this register
//   clr        - flush; wins over inc/dec
//   cnt        - current count of in-flight writes
//   underflow  - writeback seen while the count is zero (count then stays at zero)
module regfile_wb_sink_sb_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [Width-1:0] cnt,
  output logic             underflow
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             is_zero;

  assign is_zero   = (cnt_q == '0);
  assign underflow = dec & is_zero;
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      // The issue side never asserts inc at max without a matching dec.
      cnt_d = cnt_q + Width'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sink.sv
// Receiving end of the writeback stream: commits retiring results into the GPR file,
// tracks in-flight writes per register, offers two bypassed read ports and counts retires.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-low reset
//   bus (slave)     - writeback beat in, issue request in, issue_ready out
//   flush           - squash all pending-write counters
//   ra1, ra2        - read addresses
//   rd1, rd2        - read data with same-cycle writeback bypass
//   busy1, busy2    - source still has an uncommitted producer in flight
//   retire_cnt      - wrapping count of wb_valid cycles
//   sb_err          - sticky: writeback arrived for a register with no pending write
module regfile_wb_sink
  import regfile_wb_sink_pkg::*;
#(
  parameter int unsigned CntWidth = CNTW
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_wb_sink_if.slave        bus,
  input  logic                    flush,
  input  creg_addr_t              ra1,
  input  creg_addr_t              ra2,
  output logic [XLEN-1:0]         rd1,
  output logic [XLEN-1:0]         rd2,
  output logic                    busy1,
  output logic                    busy2,
  output logic [63:0]             retire_cnt,
  output logic                    sb_err
);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [XLEN-1:0]              gpr_q [NREG];
  logic [NREG-1:0][CntWidth-1:0] cnt;
  logic [NREG-1:0]              uflow;
  logic                         commit;
  logic                         issue_full;
  logic                         issue_inc;
  logic [63:0]                  retire_cnt_q;
  logic                         sb_err_q;

  // Commit also serves as the scoreboard decrement.
  assign commit = bus.wb.valid & bus.wb.regwrite & (bus.wb.dst != '0);

  // A full counter may still accept an issue when the same register retires this cycle.
  assign issue_full      = bus.issue_regwrite & (bus.issue_dst != '0) &
                           (cnt[bus.issue_dst] == CntMax);
  assign bus.issue_ready = ~issue_full | (commit & (bus.wb.dst == bus.issue_dst));
  assign issue_inc       = bus.issue_valid & bus.issue_regwrite & (bus.issue_dst != '0) &
                           bus.issue_ready;

  // Scoreboard counters; x0 has none.
  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_sb
    regfile_wb_sink_sb_counter #(
      .Width (CntWidth)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (issue_inc & (bus.issue_dst == creg_addr_t'(i))),
      .dec       (commit & (bus.wb.dst == creg_addr_t'(i))),
      .clr       (flush),
      .cnt       (cnt[i]),
      .underflow (uflow[i])
    );
  end

  // GPR storage; entry 0 is cleared on reset and never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (commit) begin
      gpr_q[bus.wb.dst] <= bus.wb.data;
    end
  end

  // Read ports with writeback bypass.
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (commit && (bus.wb.dst == ra1)) begin
        rd1 = bus.wb.data;
      end else begin
        rd1 = gpr_q[ra1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (commit && (bus.wb.dst == ra2)) begin
        rd2 = bus.wb.data;
      end else begin
        rd2 = gpr_q[ra2];
      end
    end
  end

  // A source whose last producer is retiring right now is already available via bypass.
  logic [CntWidth-1:0] cnt_ra1, cnt_ra2;
  assign cnt_ra1 = cnt[ra1];
  assign cnt_ra2 = cnt[ra2];

  assign busy1 = (ra1 != '0) & (cnt_ra1 != '0) &
                 ~((cnt_ra1 == CntOne) & commit & (bus.wb.dst == ra1));
  assign busy2 = (ra2 != '0) & (cnt_ra2 != '0) &
                 ~((cnt_ra2 == CntOne) & commit & (bus.wb.dst == ra2));

  // Retire counter counts every valid beat, including non-writing ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_cnt_q <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      if (bus.wb.valid) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
      if (|uflow) begin
        sb_err_q <= 1'b1;
      end
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign sb_err     = sb_err_q;

endmodule
